// File: rtl/resp_misr_pkg.sv
// resp_misr_pkg
// Shared definitions for the response MISR block. It holds the FSM state
// encoding and the default feedback polynomial and seed. The defaults match
// a 16-bit CRC-CCITT style Galois register.
package resp_misr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CMP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [15:0] DEF_POLY = 16'h1021;
  localparam logic [15:0] DEF_SEED = 16'h0000;

endpackage

// File: rtl/resp_misr_if.sv
// resp_misr_if
// Groups the control, response-stream and status signals of resp_misr.
//   master : test controller side (drives start/abort/pat_total/golden and
//            the response stream, observes status)
//   slave  : resp_misr side
// Signals:
//   start, abort          one-cycle run control requests
//   pat_total[15:0]       number of response words in the run
//   golden[SIG_W-1:0]     expected signature
//   resp_valid/resp_data  response word stream, resp_ready is the handshake
//   busy, done, pass      run status
//   signature, pat_count  current signature and accepted word count
interface resp_misr_if #(
  parameter int IN_W  = 1,
  parameter int SIG_W = 16
) ();

  logic             start;
  logic             abort;
  logic [15:0]      pat_total;
  logic [SIG_W-1:0] golden;
  logic             resp_valid;
  logic [IN_W-1:0]  resp_data;
  logic             resp_ready;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;
  logic [15:0]      pat_count;

  modport master (
    output start, abort, pat_total, golden, resp_valid, resp_data,
    input  resp_ready, busy, done, pass, signature, pat_count
  );

  modport slave (
    input  start, abort, pat_total, golden, resp_valid, resp_data,
    output resp_ready, busy, done, pass, signature, pat_count
  );

endinterface

// File: rtl/resp_misr_step.sv
// misr_step
// Combinational next-signature function of a Galois-form MISR.
//   sig_i  : current signature
//   data_i : response word, zero-extended into the low bits
//   sig_o  : signature after absorbing data_i
// The x^SIG_W term is implicit: when the MSB is shifted out, POLY is folded
// back into the register.
module misr_step
  import resp_misr_pkg::*;
#(
  parameter int               IN_W  = 1,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = DEF_POLY
) (
  input  logic [SIG_W-1:0] sig_i,
  input  logic [IN_W-1:0]  data_i,
  output logic [SIG_W-1:0] sig_o
);

  logic [SIG_W-1:0] fb;

  assign fb    = sig_i[SIG_W-1] ? POLY : '0;
  assign sig_o = {sig_i[SIG_W-2:0], 1'b0} ^ fb ^ SIG_W'(data_i);

endmodule

// File: rtl/resp_misr.sv
// resp_misr
// Compacts a stream of response words into a signature and compares the
// result against a golden value at the end of the run.
// Ports:
//   clk    : clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : resp_misr_if.slave, carries run control, response stream
//            and status (see resp_misr_if)
// Flow: IDLE/DONE --start--> RUN (or CMP directly for an empty run),
// RUN --last word--> CMP --one cycle--> DONE. abort returns to IDLE from
// any state and beats a simultaneous start.
module resp_misr
  import resp_misr_pkg::*;
#(
  parameter int               IN_W  = 1,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED  = DEF_SEED
) (
  input logic         clk,
  input logic         rst_n,
  resp_misr_if.slave  bus
);

  state_e           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      total_q, total_d;
  logic             pass_q, pass_d;
  logic [SIG_W-1:0] sig_next;
  logic             xfer;

  misr_step #(
    .IN_W  (IN_W),
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_step (
    .sig_i  (sig_q),
    .data_i (bus.resp_data),
    .sig_o  (sig_next)
  );

  // resp_ready depends on state only, so the transfer qualifier does too.
  assign xfer = bus.resp_valid && (state_q == ST_RUN);

  // Next-state logic. abort is checked first so it overrides start and any
  // transfer in the same cycle; signature and count simply hold.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    total_d = total_q;
    pass_d  = pass_q;
    if (bus.abort) begin
      state_d = ST_IDLE;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            sig_d   = SEED;
            cnt_d   = '0;
            total_d = bus.pat_total;
            pass_d  = 1'b0;
            state_d = (bus.pat_total == 16'd0) ? ST_CMP : ST_RUN;
          end
        end
        ST_RUN: begin
          if (xfer) begin
            sig_d = sig_next;
            cnt_d = cnt_q + 16'd1;
            // Leave RUN on the edge that takes the final word.
            if ((cnt_q + 16'd1) == total_q) begin
              state_d = ST_CMP;
            end
          end
        end
        ST_CMP: begin
          pass_d  = (sig_q == bus.golden);
          state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      total_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.resp_ready = (state_q == ST_RUN);
  assign bus.busy       = (state_q == ST_RUN) || (state_q == ST_CMP);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.pass       = pass_q;
  assign bus.signature  = sig_q;
  assign bus.pat_count  = cnt_q;

endmodule

// File: tb/tb_resp_misr.sv
// tb_resp_misr
// Scoreboard bench for resp_misr with default parameters. Each completed
// run pushes its expected signature/pass/count into a queue; a monitor pops
// and compares whenever done rises.
module tb_resp_misr;
  import resp_misr_pkg::*;

  localparam int IN_W  = 1;
  localparam int SIG_W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  resp_misr_if #(.IN_W(IN_W), .SIG_W(SIG_W)) bus ();

  resp_misr #(
    .IN_W  (IN_W),
    .SIG_W (SIG_W),
    .POLY  (16'h1021),
    .SEED  (16'h0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] sig;
    logic        pass;
    logic [15:0] cnt;
    int          total;
  } expT;

  expT  expQ[$];
  logic wordQ[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   lastAcc  = -100;
  logic donePrev = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference signature of the first n queued words: doubling the value,
  // reducing by x^16 + POLY when it overflows 16 bits, then adding the word
  // in GF(2).
  function automatic logic [15:0] refSig(input int n);
    int s;
    s = 0;
    for (int i = 0; i < n; i++) begin
      s = s * 2;
      if (s >= 65536) s = (s - 65536) ^ 32'h1021;
      s = s ^ int'(wordQ[i]);
    end
    return s[15:0];
  endfunction

  // Scoreboard monitor: samples on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        donePrev = 1'b0;
      end else begin
        if (bus.resp_valid && bus.resp_ready) lastAcc = cyc;
        if (bus.done && !donePrev) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_done", expQ.size(), 1);
          end else begin
            expT e;
            e = expQ.pop_front();
            checkOutput("signature", bus.signature, e.sig);
            checkOutput("pass", bus.pass, e.pass);
            checkOutput("pat_count", bus.pat_count, e.cnt);
            checkOutput("busy_at_done", bus.busy, 0);
            if (e.total > 0) checkOutput("done_latency", cyc - lastAcc, 2);
          end
        end
        donePrev = bus.done;
      end
    end
  end

  task automatic startRun(input int total, input logic [15:0] gold);
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.pat_total = 16'(total);
    bus.golden    = gold;
    @(posedge clk); #1;
    bus.start     = 1'b0;
  endtask

  // Presents words [first, first+n) with random idle gaps, checking ready
  // through gaps and the running signature after each accept.
  task automatic feedWords(input int first, input int n, input int maxGap);
    for (int i = first; i < first + n; i++) begin
      int gap;
      gap = $urandom_range(maxGap, 0);
      repeat (gap) begin
        bus.resp_valid = 1'b0;
        checkOutput("ready_in_gap", bus.resp_ready, 1);
        @(posedge clk); #1;
      end
      checkOutput("ready_before_word", bus.resp_ready, 1);
      bus.resp_valid = 1'b1;
      bus.resp_data  = wordQ[i];
      @(posedge clk); #1;
      bus.resp_valid = 1'b0;
      checkOutput("sig_step", bus.signature, refSig(i + 1));
      checkOutput("count_step", bus.pat_count, i + 1);
    end
  endtask

  // Full run over wordQ[0 .. total-1]; pushes the expected result first.
  task automatic applyStimulus(input int total, input logic [15:0] gold, input int maxGap);
    expT e;
    int  k;
    e.sig   = refSig(total);
    e.pass  = (refSig(total) == gold);
    e.cnt   = 16'(total);
    e.total = total;
    expQ.push_back(e);
    startRun(total, gold);
    feedWords(0, total, maxGap);
    checkOutput("ready_after_last", bus.resp_ready, 0);
    k = 0;
    while (!bus.done && k < 20) begin
      checkOutput("ready_low_wait", bus.resp_ready, 0);
      @(posedge clk); #1;
      k++;
    end
    checkOutput("done_seen", bus.done, 1);
    @(negedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.pat_total  = '0;
    bus.golden     = '0;
    bus.resp_valid = 1'b0;
    bus.resp_data  = '0;

    #2;
    checkOutput("rst_signature", bus.signature, 16'h0000);
    checkOutput("rst_count", bus.pat_count, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_ready", bus.resp_ready, 0);
    checkOutput("rst_pass", bus.pass, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] words 1,0,1 back-to-back");
    wordQ = '{1'b1, 1'b0, 1'b1};
    applyStimulus(3, 16'h0005, 0);

    $display("[TB] 17-word run, matching and mismatching golden");
    wordQ.delete();
    wordQ.push_back(1'b1);
    repeat (16) wordQ.push_back(1'b0);
    checkOutput("model_0x8000", refSig(16), 16'h8000);
    applyStimulus(17, 16'h1021, 0);
    applyStimulus(17, 16'h1020, 1);

    $display("[TB] words 1,0,1 with idle gaps");
    wordQ = '{1'b1, 1'b0, 1'b1};
    applyStimulus(3, 16'h0005, 4);

    $display("[TB] empty run");
    wordQ.delete();
    applyStimulus(0, 16'h0000, 0);

    $display("[TB] abort with simultaneous start after two words");
    wordQ = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    startRun(5, 16'h0000);
    feedWords(0, 2, 1);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checkOutput("abort_busy", bus.busy, 0);
    checkOutput("abort_ready", bus.resp_ready, 0);
    checkOutput("abort_count", bus.pat_count, 2);
    checkOutput("abort_sig", bus.signature, 16'h0003);
    checkOutput("abort_pass", bus.pass, 0);
    @(posedge clk); #1;
    checkOutput("abort_idle_done", bus.done, 0);
    applyStimulus(5, refSig(5), 2);

    $display("[TB] asynchronous reset mid-run");
    wordQ.delete();
    repeat (6) wordQ.push_back(1'($urandom_range(1, 0)));
    startRun(6, 16'h0000);
    feedWords(0, 2, 0);
    bus.resp_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_signature", bus.signature, 16'h0000);
    checkOutput("arst_count", bus.pat_count, 0);
    checkOutput("arst_busy", bus.busy, 0);
    checkOutput("arst_ready", bus.resp_ready, 0);
    checkOutput("arst_done", bus.done, 0);
    checkOutput("arst_pass", bus.pass, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_count", bus.pat_count, 0);
    checkOutput("release_busy", bus.busy, 0);
    bus.resp_valid = 1'b0;
    applyStimulus(6, refSig(6), 3);

    $display("[TB] randomized runs");
    for (int r = 0; r < 8; r++) begin
      int          total;
      logic [15:0] gold;
      total = $urandom_range(20, 1);
      wordQ.delete();
      repeat (total) wordQ.push_back(1'($urandom_range(1, 0)));
      gold = refSig(total) ^ 16'($urandom_range(1, 0));
      applyStimulus(total, gold, 3);
    end

    repeat (3) @(negedge clk);
    #1;
    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/resp_misr.md
RESP_MISR -- requirements
Module: resp_misr

Interface
REQ-001 Parameter IN_W, default 1, width of one response word from the circuit under test.
REQ-002 Parameter SIG_W, default 16, signature register width (SIG_W >= IN_W).
REQ-003 Parameter POLY, default 16'h1021, feedback polynomial (Galois form, x^SIG_W implicit).
REQ-004 Parameter SEED, default 0, signature value loaded on start.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 start  input  1  one-cycle request to begin a compaction run.
REQ-008 abort  input  1  one-cycle request to cancel any run, return to IDLE.
REQ-009 pat_total  input  16  number of response words in the run, sampled on accepted start.
REQ-010 golden  input  SIG_W  expected signature, sampled in CMP.
REQ-011 resp_valid  input  1  response word present.
REQ-012 resp_data  input  IN_W  response word (pattern output captured from the gate).
REQ-013 resp_ready  output  1  block will accept resp_data this cycle.
REQ-014 busy  output  1  high in RUN and CMP.
REQ-015 done  output  1  high in DONE.
REQ-016 pass  output  1  signature matched golden; valid while done.
REQ-017 signature  output  SIG_W  current signature register.
REQ-018 pat_count  output  16  words accepted in current/last run.

Function
REQ-019 FSM states IDLE, RUN, CMP, DONE; one-hot or binary is free.
REQ-020 IDLE/DONE + start (abort low): signature<=SEED, pat_count<=0, latch pat_total, clear pass; go RUN, or CMP if pat_total==0.
REQ-021 Start while in RUN or CMP is ignored.
REQ-022 resp_ready = 1 only in RUN; combinational from state only, never from resp_valid.
REQ-023 Transfer = resp_valid & resp_ready; on transfer signature <= (signature<<1) ^ (signature[SIG_W-1] ? POLY : 0) ^ zero-extended resp_data, pat_count <= pat_count+1.
REQ-024 No transfer -> signature and pat_count hold.
REQ-025 Transfer making pat_count equal latched pat_total moves RUN->CMP on the same edge; no further words accepted.
REQ-026 CMP lasts exactly one cycle: pass <= (signature == golden); go DONE.
REQ-027 DONE holds done, pass, signature, pat_count until start or abort.
REQ-028 abort in any state: go IDLE next edge; signature and pat_count hold, pass cleared; abort wins over simultaneous start.
REQ-029 pat_count is 16-bit; pat_total 0xFFFF completes without wrap; no counter wraps within a legal run.
REQ-030 Latency: done asserts 2 cycles after the edge accepting the final word.

Reset
REQ-031 rst_n low: state IDLE, signature SEED, pat_count 0, pass 0, done 0, busy 0, resp_ready 0, immediately and asynchronously.
REQ-032 Reset mid-run discards the run; no transfer is counted on the release edge.

Structure
REQ-033 Shared package holds the state enum, default POLY and SEED constants.
REQ-034 One sub-module, misr_step: combinational next-signature function of (signature, resp_data, POLY).

Verification
REQ-035 Defaults, pat_total=3, words 1,0,1 back-to-back, golden 0x0005 -> signature 0x0001,0x0002,0x0005; done 2 cycles after last accept, pass=1, pat_count=3.
REQ-036 pat_total=17, word 1 then 16 zeros -> signature 0x8000 after 16 words, 0x1021 after 17th; golden 0x1021 -> pass=1; golden 0x1020 -> pass=0.
REQ-037 pat_total=3 with resp_valid gaps of 0-4 idle cycles -> same signature 0x0005; resp_ready stays high through gaps, drops at CMP.
REQ-038 pat_total=0, start -> CMP then DONE with signature 0x0000; golden 0 -> pass=1; resp_ready never high.
REQ-039 abort and start together mid-run after 2 words -> IDLE, pat_count=2, pass=0; later start restarts from SEED.
REQ-040 rst_n asserted asynchronously mid-run between clock edges -> all outputs at reset values before next edge; start after release runs normally.
